// File: rtl/audio_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : audio_reset_seq
// Brief    : Lock-qualified, staggered reset sequencer for the 12.288 MHz
//            audio domain. Optional macro AUDIO_RST_CAUSE_EN adds rst_cause.
// Revision : 1.0 - initial release
// ============================================================================
module audio_reset_seq #(
    parameter int SYNC_STAGES    = 3,
    parameter int NUM_OUT        = 4,
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic               clk_12m288,
    input  logic               resetn,
    input  logic               locked,
    input  logic               soft_rst,
    output logic [NUM_OUT-1:0] reset_n,
    output logic               ready
`ifdef AUDIO_RST_CAUSE_EN
    ,
    output logic [1:0]         rst_cause
`endif
);

    localparam int c_stagger_span = STAGGER_CYCLES * (NUM_OUT - 1);
    localparam int c_cnt_need     = (HOLD_CYCLES > c_stagger_span) ? HOLD_CYCLES : c_stagger_span;
    localparam bit c_all_at_once  = (NUM_OUT == 1) || (STAGGER_CYCLES == 0);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || NUM_OUT < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 0) begin : g_param_err
            $error("audio_reset_seq: parameter out of range");
        end
        if ((c_cnt_need >> CNT_W) != 0) begin : g_cnt_w_err
            $error("audio_reset_seq: CNT_W too small for HOLD_CYCLES / stagger span");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [NUM_OUT-1:0]       r_reset_n;
    logic                     r_ready;
    logic [SYNC_STAGES-1:0]   r_src_sync;
    logic [SYNC_STAGES-1:0]   r_lock_sync;
    logic [NUM_OUT-1:0]       w_hit;
    logic                     w_src_ok_q;
    logic                     w_restart;

    // Both chains are cleared by resetn so lock is re-qualified after every reset.
    always_ff @(posedge clk_12m288 or negedge resetn) begin
        if (!resetn) begin
            r_src_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_src_sync  <= {r_src_sync[SYNC_STAGES-2:0], 1'b1};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], locked};
        end
    end

    assign w_src_ok_q = r_src_sync[SYNC_STAGES-1] & r_lock_sync[SYNC_STAGES-1];
    assign w_restart  = ~w_src_ok_q | soft_rst;

    always_comb begin
        w_hit = '0;
        for (int k = 1; k < NUM_OUT; k++) begin
            w_hit[k] = (r_cnt == CNT_W'(k * STAGGER_CYCLES - 1));
        end
    end

`ifdef AUDIO_RST_CAUSE_EN
    logic [1:0] r_rst_cause;
    assign rst_cause = r_rst_cause;
`endif

    always_ff @(posedge clk_12m288 or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_reset_n <= '0;
            r_ready   <= 1'b0;
`ifdef AUDIO_RST_CAUSE_EN
            r_rst_cause <= 2'b00;
`endif
        end else if (w_restart) begin
            r_state   <= ST_HOLD;
            r_cnt     <= '0;
            r_reset_n <= '0;
            r_ready   <= 1'b0;
`ifdef AUDIO_RST_CAUSE_EN
            if (!r_src_sync[SYNC_STAGES-1])
                r_rst_cause <= 2'b00;
            else if (!r_lock_sync[SYNC_STAGES-1])
                r_rst_cause <= 2'b01;
            else
                r_rst_cause <= 2'b10;
`endif
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        r_cnt <= '0;
                        if (c_all_at_once) begin
                            r_reset_n <= '1;
                            r_state   <= ST_RUN;
                        end else begin
                            r_reset_n <= NUM_OUT'(1);
                            r_state   <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Bit 0 is already set, so OR-ing the hit vector keeps release order monotonic.
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_reset_n <= r_reset_n | w_hit;
                    if (w_hit[NUM_OUT-1])
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign reset_n = r_reset_n;
    assign ready   = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_audio_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_reset_seq
// Brief    : Self-checking bench for audio_reset_seq (staggered and
//            all-at-once instances) against a clean-run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_reset_seq;

    localparam int SYNC = 2;
    localparam int HOLD = 8;
    localparam int STAG = 4;

    logic       clk_12m288 = 1'b0;
    logic       resetn     = 1'b0;
    logic       locked     = 1'b1;
    logic       soft_rst   = 1'b0;
    logic [2:0] rn_a;
    logic       rdy_a;
    logic [3:0] rn_b;
    logic       rdy_b;
`ifdef AUDIO_RST_CAUSE_EN
    logic [1:0] cause_a;
    logic [1:0] cause_b;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_12m288 = ~clk_12m288;

    audio_reset_seq #(
        .SYNC_STAGES(SYNC), .NUM_OUT(3), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .CNT_W(16)
    ) dut_a (
        .clk_12m288(clk_12m288), .resetn(resetn), .locked(locked), .soft_rst(soft_rst),
        .reset_n(rn_a), .ready(rdy_a)
`ifdef AUDIO_RST_CAUSE_EN
        , .rst_cause(cause_a)
`endif
    );

    audio_reset_seq #(
        .SYNC_STAGES(SYNC), .NUM_OUT(4), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(0), .CNT_W(16)
    ) dut_b (
        .clk_12m288(clk_12m288), .resetn(resetn), .locked(locked), .soft_rst(soft_rst),
        .reset_n(rn_b), .ready(rdy_b)
`ifdef AUDIO_RST_CAUSE_EN
        , .rst_cause(cause_b)
`endif
    );

    // Reference model: m_run counts consecutive edges on which the source was
    // clean (resetn seen high for SYNC edges, locked seen SYNC edges ago, no soft_rst).
    int         m_rcnt = 0;
    int         m_run  = 0;
    bit         m_hist [SYNC];
    logic [1:0] m_cause = 2'b00;

    always @(posedge clk_12m288 or negedge resetn) begin
        if (!resetn) begin
            m_rcnt  = 0;
            m_run   = 0;
            m_cause = 2'b00;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
        end else begin
            bit src_ok;
            bit lock_s;
            src_ok = (m_rcnt >= SYNC);
            lock_s = m_hist[SYNC-1];
            if (src_ok && lock_s && !soft_rst) begin
                if (m_run < 10000) m_run = m_run + 1;
            end else begin
                m_run   = 0;
                m_cause = !src_ok ? 2'b00 : (!lock_s ? 2'b01 : 2'b10);
            end
            if (m_rcnt < 10000) m_rcnt = m_rcnt + 1;
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = locked;
        end
    end

    function automatic logic [2:0] exp_a(input int run);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = (run >= HOLD + k * STAG);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        chk("a.reset_n", {1'b0, rn_a}, {1'b0, exp_a(m_run)});
        chk("a.ready", {3'b0, rdy_a}, {3'b0, m_run >= HOLD + 2 * STAG + 1});
        chk("b.reset_n", rn_b, {4{m_run >= HOLD}});
        chk("b.ready", {3'b0, rdy_b}, {3'b0, m_run >= HOLD + 1});
        chk("a.order", {1'b0, rn_a & (rn_a + 3'd1)}, 4'd0);
`ifdef AUDIO_RST_CAUSE_EN
        chk("a.cause", {2'b0, cause_a}, {2'b0, m_cause});
        chk("b.cause", {2'b0, cause_b}, {2'b0, m_cause});
`endif
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_12m288);
            check_model();
        end
    endtask

    // Directed timing of one full sequence; first = edges until bit 0 releases.
    task automatic seq_check(input int first);
        step(first - 1);
        chk("seq.a_pre", {1'b0, rn_a}, 4'b0000);
        chk("seq.b_pre", rn_b, 4'b0000);
        step(1);
        chk("seq.a_bit0", {1'b0, rn_a}, 4'b0001);
        chk("seq.b_all", rn_b, 4'b1111);
        chk("seq.b_rdy_lo", {3'b0, rdy_b}, 4'd0);
        step(1);
        chk("seq.b_rdy_hi", {3'b0, rdy_b}, 4'd1);
        step(3);
        chk("seq.a_bit1", {1'b0, rn_a}, 4'b0011);
        step(4);
        chk("seq.a_bit2", {1'b0, rn_a}, 4'b0111);
        chk("seq.a_rdy_lo", {3'b0, rdy_a}, 4'd0);
        step(1);
        chk("seq.a_rdy_hi", {3'b0, rdy_a}, 4'd1);
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst.a", {rdy_a, rn_a}, 4'b0000);
        chk("rst.b", rn_b, 4'b0000);
        chk("rst.b_rdy", {3'b0, rdy_b}, 4'd0);

        // Release timing, staggered and all-together
        resetn = 1'b1;
        seq_check(SYNC + HOLD);

        // Soft reset pulse in RUN
        step(5);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        chk("soft.a", {rdy_a, rn_a}, 4'b0000);
        chk("soft.b", rn_b, 4'b0000);
`ifdef AUDIO_RST_CAUSE_EN
        chk("soft.cause", {2'b0, cause_a}, 4'b0010);
`endif
        seq_check(HOLD);

        // Lock loss during RELEASE with only bit 0 released
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        step(HOLD + 1);
        chk("lock.pre", {1'b0, rn_a}, 4'b0001);
        locked = 1'b0;
        step(3);
        chk("lock.a", {rdy_a, rn_a}, 4'b0000);
        chk("lock.b", rn_b, 4'b0000);
`ifdef AUDIO_RST_CAUSE_EN
        chk("lock.cause", {2'b0, cause_a}, 4'b0001);
`endif
        locked = 1'b1;
        seq_check(SYNC + HOLD);

        // Asynchronous resetn assertion mid-RUN, between clock edges
        step(3);
        #3 resetn = 1'b0;
        #1;
        chk("async.a", {rdy_a, rn_a}, 4'b0000);
        chk("async.b", {3'b0, rdy_b}, 4'd0);
        chk("async.b_rn", rn_b, 4'b0000);
`ifdef AUDIO_RST_CAUSE_EN
        chk("async.cause", {2'b0, cause_a}, 4'b0000);
`endif
        @(negedge clk_12m288);
        resetn = 1'b1;
        seq_check(SYNC + HOLD);

        // soft_rst held for 20 cycles after resetn release
        resetn = 1'b0;
        step(2);
        resetn   = 1'b1;
        soft_rst = 1'b1;
        step(20);
        chk("softhold.a", {rdy_a, rn_a}, 4'b0000);
        chk("softhold.b", rn_b, 4'b0000);
        soft_rst = 1'b0;
        seq_check(HOLD);

        // Randomized disturbances checked against the model every cycle
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(5, 40));
            case ($urandom_range(0, 3))
                0: begin
                    soft_rst = 1'b1;
                    step($urandom_range(1, 3));
                    soft_rst = 1'b0;
                end
                1: begin
                    locked = 1'b0;
                    step($urandom_range(1, 6));
                    locked = 1'b1;
                end
                2: begin
                    #($urandom_range(1, 3)) resetn = 1'b0;
                    #1;
                    chk("rand.async_a", {rdy_a, rn_a}, 4'b0000);
                    chk("rand.async_b", rn_b, 4'b0000);
                    @(negedge clk_12m288);
                    check_model();
                    resetn = 1'b1;
                end
                default: begin
                    soft_rst = 1'b0;
                end
            endcase
        end
        step(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_reset_seq.md
Name: audio_reset_seq

Overview:
Parametrised reset sequencer for the 12.288 MHz audio clock domain. It replaces the single-flop audio reset with the following features:
- N-stage synchroniser.
- PLL/MMCM lock qualification.
- Minimum hold time.
- Staggered release of several active-low reset outputs, e.g. I2S, PDM mic, filter, mixer.
- Synchronous soft-reset request and a ready flag.

Parameters:
SYNC_STAGES, 3, synchroniser depth for resetn deassertion and for locked (min 2)
NUM_OUT, 4, number of sequenced reset outputs (min 1)
HOLD_CYCLES, 1024, clk cycles all outputs stay asserted after the synchronised source goes clean (min 1)
STAGGER_CYCLES, 16, clk cycles between consecutive output releases (0 = release all together)
CNT_W, 16, counter width; must hold max(HOLD_CYCLES, STAGGER_CYCLES*(NUM_OUT-1)); elaboration error otherwise

Ports:
clk_12m288  in  1  audio clock
resetn  in  1  asynchronous, active-low reset
locked  in  1  clock-generator lock, asynchronous to clk_12m288, high = locked
soft_rst  in  1  synchronous single-cycle request, active high
reset_n  out  NUM_OUT  sequenced resets, active low; bit 0 released first
ready  out  1  high when all outputs are released (state RUN)

Behaviour:
- Reset values (resetn low): reset_n = all 0, ready = 0, FSM = HOLD, counter = 0, synchroniser flops = 0.
- Assertion via resetn:
  - Asynchronous; all reset_n bits go 0 immediately.
  - Deassertion passes through the SYNC_STAGES chain, giving src_ok.
- locked:
  - Passes through its own SYNC_STAGES synchroniser, giving lock_s.
  - src_ok_q = src_ok & lock_s.
  - Loss of lock asserts all outputs synchronously within SYNC_STAGES+1 cycles.
- FSM states HOLD, RELEASE, RUN.
- HOLD:
  - counter clears while src_ok_q = 0.
  - counter increments while src_ok_q = 1.
  - On the edge where counter == HOLD_CYCLES-1: go to RELEASE, clear counter, set reset_n[0] = 1.
- RELEASE:
  - counter increments each cycle.
  - reset_n[k] set on the edge where counter == k*STAGGER_CYCLES-1 (k ≥ 1).
  - On the edge that releases bit NUM_OUT-1: go to RUN.
  - If NUM_OUT = 1 or STAGGER_CYCLES = 0: all bits release on the HOLD exit edge and the FSM goes straight to RUN.
- RUN: ready = 1, registered, one cycle after the final release edge.
- Any state, src_ok_q = 0 or soft_rst = 1 (synchronous path): next edge gives reset_n = 0, ready = 0, counter = 0, FSM = HOLD. This restarts the full HOLD/RELEASE sequence.
- soft_rst held high keeps the block in HOLD with counter 0; the sequence starts on the first cycle it is low.
- soft_rst and src_ok_q loss on the same cycle are treated as a single restart.
- Release order is strictly monotonic: reset_n[k] = 1 implies reset_n[j] = 1 for all j < k, at every cycle.
- Latency from the resetn rising edge to reset_n[0] rising: SYNC_STAGES + HOLD_CYCLES clk edges (+1 for metastability resolution), assuming lock_s is already 1.
- Counter never wraps; it stops at its terminal value in RUN.

Optional Feature:
Macro AUDIO_RST_CAUSE_EN.
- When defined:
  - Adds output rst_cause[1:0], a sticky code for the last restart: 00 = resetn, 01 = lock loss, 10 = soft_rst.
  - Value is updated on the edge entering HOLD.
  - Priority when simultaneous: resetn > lock loss > soft_rst.
  - Reset value is 00.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. SYNC_STAGES=2, HOLD=8, STAGGER=4, NUM_OUT=3, locked=1; release resetn at edge 0. Required: reset_n[0] rises at edge 10(±1), [1] at 14, [2] at 18, ready at 19.
2. In RUN, pulse soft_rst for 1 cycle. Required: the next edge gives reset_n = 000 and ready = 0, and the full sequence repeats with the same spacing. With the cause macro defined, rst_cause = 10.
3. During RELEASE with only reset_n[0] high, drop locked. Required: all outputs are 0 within 3 edges, no bit is ever released out of order, and the sequence restarts after locked returns. rst_cause = 01.
4. Assert resetn low asynchronously mid-RUN, between clock edges. Required: reset_n = 0 and ready = 0 with no clock edge; on release, the timing from scenario 1 is reproduced.
5. STAGGER_CYCLES=0, NUM_OUT=4. Required: all four bits rise on the same edge, SYNC_STAGES+HOLD edges after release, and ready rises one edge later.
6. Hold soft_rst high for 20 cycles after resetn release. Required: counter stays 0 and outputs stay 0; HOLD starts counting on the first low cycle.
